// File: rtl/gpr_file_mp_if.sv
// Bus bundle between issue/writeback stages and the multi-ported register file.
// The master drives addresses, writes and busy claims; the slave returns read data and busy state.
interface gpr_file_mp_if #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 1
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic [NWR-1:0]      wen;
   logic [NWR*AW-1:0]   waddr;
   logic [NWR*XLEN-1:0] wdata;
   logic                set_en;
   logic [AW-1:0]       set_addr;
   logic [AW-1:0]       dbg_addr;
   logic [XLEN-1:0]     dbg_data;
   logic                any_busy;

   modport master (
      output raddr, wen, waddr, wdata, set_en, set_addr, dbg_addr,
      input  rdata, rbusy, dbg_data, any_busy
   );

   modport slave (
      input  raddr, wen, waddr, wdata, set_en, set_addr, dbg_addr,
      output rdata, rbusy, dbg_data, any_busy
   );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-ported general-purpose register file with optional same-cycle write bypass
// and a per-register busy scoreboard (set at issue, cleared at writeback).
module gpr_file_mp #(
   parameter int XLEN    = 64,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter int NWR     = 1,
   parameter bit ZERO_R0 = 1'b1,
   parameter bit BYPASS  = 1'b1
) (
   input logic          clock,
   input logic          reset_n,
   gpr_file_mp_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] busy;

   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic [AW-1:0]   ra [NRD];
   logic [XLEN-1:0] rd [NRD];
   logic [NRD-1:0]  rb;

   // NREG may be below 2**AW, so the upper codes are treated as holes.
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < (AW+1)'(NREG);
   endfunction

   function automatic logic usable(input logic [AW-1:0] a);
      return in_range(a) && !(ZERO_R0 && (a == '0));
   endfunction

   for (genvar j = 0; j < NWR; j++) begin : g_wr
      assign wa[j] = bus.waddr[j*AW +: AW];
      assign wd[j] = bus.wdata[j*XLEN +: XLEN];
   end

   for (genvar i = 0; i < NRD; i++) begin : g_ra
      assign ra[i] = bus.raddr[i*AW +: AW];
   end

   // Ascending port order makes the highest-index writer win on address collisions.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREG; r++) begin
            rf[r] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wen[j] && usable(wa[j])) begin
               rf[wa[j]] <= wd[j];
            end
         end
      end
   end

   // Set is applied after the clears so a newer producer keeps the register busy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wen[j] && usable(wa[j])) begin
               busy[wa[j]] <= 1'b0;
            end
         end
         if (bus.set_en && usable(bus.set_addr)) begin
            busy[bus.set_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd[i] = '0;
         rb[i] = 1'b0;
         if (usable(ra[i])) begin
            rd[i] = rf[ra[i]];
            rb[i] = busy[ra[i]];
            if (BYPASS && reset_n) begin
               for (int j = 0; j < NWR; j++) begin
                  if (bus.wen[j] && (wa[j] == ra[i])) begin
                     rd[i] = wd[j];
                     rb[i] = 1'b0;
                  end
               end
            end
         end
      end
   end

   logic [NRD*XLEN-1:0] rdata_flat;

   always_comb begin
      rdata_flat = '0;
      for (int i = 0; i < NRD; i++) begin
         rdata_flat[i*XLEN +: XLEN] = rd[i];
      end
   end

   assign bus.rdata    = rdata_flat;
   assign bus.rbusy    = rb;
   assign bus.dbg_data = in_range(bus.dbg_addr) ? rf[bus.dbg_addr] : '0;
   assign bus.any_busy = |busy;

   for (genvar j = 0; j < NWR; j++) begin : g_wchk
      a_waddr_range: assert property (@(posedge clock) disable iff (!reset_n)
         bus.wen[j] |-> in_range(bus.waddr[j*AW +: AW]));
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rchk
      a_raddr_range: assert property (@(posedge clock) disable iff (!reset_n)
         in_range(bus.raddr[i*AW +: AW]));
   end

   a_set_range: assert property (@(posedge clock) disable iff (!reset_n)
      bus.set_en |-> in_range(bus.set_addr));

endmodule
